// File: rtl/viterbi_frame_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// viterbi_frame_sequencer: feeds buffered codewords one at a time to a
// Viterbi decoder core and hands decoded bytes downstream.   rev 1.0
// ------------------------------------------------------------------
module viterbi_frame_sequencer #(
  parameter int IN_DEPTH   = 4,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_err,
  output logic        dec_rst,
  output logic        dec_en,
  output logic [15:0] dec_data,
  input  logic [7:0]  dec_out,
  input  logic        dec_done,
  output logic        busy,
  output logic [15:0] word_cnt
);

  localparam int          AW       = $clog2(IN_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(IN_DEPTH);
  localparam logic [15:0] LD_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  logic [15:0]   fifo_mem_q [IN_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   dec_data_q, dec_data_d;
  logic          done_prev_q, done_prev_d;
  logic [7:0]    cap_data_q, cap_data_d;
  logic          cap_err_q, cap_err_d;
  logic          m_valid_q, m_valid_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_err_q, m_err_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic          live_q;
  logic          push, pop;

  // live_q keeps s_ready and dec_rst low until the first edge after reset
  assign s_ready  = live_q && (count_q != CNT_FULL);
  assign dec_rst  = live_q && (state_q != S_LOAD);
  assign dec_en   = (state_q == S_RUN);
  assign busy     = (state_q != S_IDLE);
  assign dec_data = dec_data_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_err    = m_err_q;
  assign word_cnt = word_cnt_q;
  assign push     = s_valid && s_ready;

  always_comb begin
    pop         = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    dec_data_d  = dec_data_q;
    done_prev_d = done_prev_q;
    cap_data_d  = cap_data_q;
    cap_err_d   = cap_err_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_err_d     = m_err_q;
    word_cnt_d  = word_cnt_q;
    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (count_q != '0) begin
          pop        = 1'b1;
          dec_data_d = fifo_mem_q[rd_ptr_q];
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        // a done level left over from the previous word must not look like an edge
        done_prev_d = 1'b0;
        if (cnt_q == LD_LAST) begin
          cnt_d   = 16'd0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RUN: begin
        done_prev_d = dec_done;
        cnt_d       = cnt_q + 16'd1;
        if (dec_done && !done_prev_q) begin
          cap_data_d = dec_out;
          cap_err_d  = 1'b0;
          state_d    = S_STORE;
        end else if (cnt_q == TO_LAST) begin
          cap_data_d = 8'h00;
          cap_err_d  = 1'b1;
          state_d    = S_STORE;
        end
      end
      S_STORE: begin
        if (!m_valid_q || m_ready) begin
          m_valid_d  = 1'b1;
          m_data_d   = cap_data_q;
          m_err_d    = cap_err_q;
          word_cnt_d = word_cnt_q + 16'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      dec_data_q  <= 16'd0;
      done_prev_q <= 1'b0;
      cap_data_q  <= 8'h00;
      cap_err_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= 8'h00;
      m_err_q     <= 1'b0;
      word_cnt_q  <= 16'd0;
      live_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dec_data_q  <= dec_data_d;
      done_prev_q <= done_prev_d;
      cap_data_q  <= cap_data_d;
      cap_err_q   <= cap_err_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_err_q     <= m_err_d;
      word_cnt_q  <= word_cnt_d;
      live_q      <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/viterbi_frame_sequencer.md
VITERBI_FRAME_SEQUENCER -- requirements
Module: viterbi_frame_sequencer

Interface
REQ-001 The module SHALL have parameter IN_DEPTH, default 4, meaning input codeword FIFO depth (power of 2, >=2).
REQ-002 The module SHALL have parameter RST_CYCLES, default 2, meaning decoder reset pulse width in clocks (1..15).
REQ-003 The module SHALL have parameter TIMEOUT, default 255, meaning maximum RUN cycles before abort (1..65535).
REQ-004 The module SHALL have port sys_clk  in  1  single clock; all logic on rising edge.
REQ-005 The module SHALL have port rst  in  1  reset, asynchronous assert, active-low.
REQ-006 The module SHALL have ports s_valid in 1, s_ready out 1, s_data in 16: the codeword input handshake.
REQ-007 The module SHALL have ports m_valid out 1, m_ready in 1, m_data out 8, m_err out 1: the decoded byte output handshake; m_err=1 marks a timed-out word.
REQ-008 The module SHALL have ports dec_rst out 1, dec_en out 1, dec_data out 16, driving the decoder's rst (active-low), en and i_data.
REQ-009 The module SHALL have ports dec_out in 8 and dec_done in 1, receiving the decoder's o_data and o_done.
REQ-010 The module SHALL have ports busy out 1 (FSM not IDLE) and word_cnt out 16 (words completed, including timeouts).

Function
REQ-011 An input transfer SHALL occur when s_valid&&s_ready; s_ready = FIFO not full; a push while full SHALL NOT occur.
REQ-012 An output transfer SHALL occur when m_valid&&m_ready; m_data/m_err SHALL hold stable while m_valid&&!m_ready.
REQ-013 The FSM SHALL have states IDLE, LOAD, RUN, STORE.
REQ-014 IDLE: if FIFO non-empty, pop head into dec_data register and go LOAD in the next cycle; else stay.
REQ-015 LOAD: dec_rst=0, dec_en=0 for exactly RST_CYCLES cycles, then go RUN; dec_data SHALL be stable throughout LOAD and RUN.
REQ-016 RUN: dec_rst=1, dec_en=1; the timeout counter increments each cycle from 0.
REQ-017 RUN: a rising edge of dec_done (dec_done=1 and previous-cycle sample 0) SHALL capture dec_out with err=0 and go STORE.
REQ-018 The dec_done edge detector's previous-sample flop SHALL be cleared to 0 in LOAD, so a level left high by the prior word is never taken as completion.
REQ-019 RUN: if the counter reaches TIMEOUT without an edge, capture data 8'h00 with err=1 and go STORE; an edge in the same cycle as expiry SHALL win (err=0).
REQ-020 STORE: if the output register is empty or is transferring this cycle, load it, set m_valid, increment word_cnt (wrap 16'hFFFF->0), go IDLE; otherwise stall in STORE with dec_en=0.
REQ-021 Completion latency with an empty pipeline SHALL be: push at cycle t -> LOAD at t+2 -> RUN at t+2+RST_CYCLES; m_valid 1 cycle after the capturing cycle.
REQ-022 A push and a pop in the same cycle SHALL both take effect; the FIFO count is unchanged and pointers wrap modulo IN_DEPTH.
REQ-023 Words SHALL be emitted strictly in input order, one output per accepted input.
REQ-024 In IDLE/STORE, dec_rst=1 and dec_en=0.

Reset
REQ-025 While rst=0, regardless of state: FSM=IDLE, FIFO empty, s_ready=0, m_valid=0, m_data=0, m_err=0, dec_rst=0, dec_en=0, dec_data=0, busy=0, word_cnt=0, counters 0.
REQ-026 After rst deasserts: s_ready=1 from the first clock edge, dec_rst=1; a word mid-RUN at reset is discarded with no output.

Verification
REQ-027 Single word: push 16'hDAA6, bench decoder returns 8'h5A with a dec_done edge 10 cycles into RUN -> dec_rst low exactly 2 cycles, m_data=8'h5A, m_err=0, word_cnt=1.
REQ-028 Back-to-back: push 6 words with m_ready=1 -> s_ready drops after 4 buffered words plus 1 in flight; 6 outputs in order; word_cnt=6.
REQ-029 Sticky done: decoder holds dec_done=1 after word 1 until its reset -> word 2 is not captured until a fresh edge; no duplicate output.
REQ-030 Timeout: decoder never asserts done, TIMEOUT=20 -> m_data=8'h00, m_err=1 at RUN cycle 20; next word then decodes normally.
REQ-031 Backpressure: m_ready=0 for 50 cycles with 3 words queued -> m_data stable, FSM stalls in STORE with dec_en=0; release -> 3 words drained in order.
REQ-032 Reset mid-RUN: assert rst in RUN cycle 5 -> all outputs at REQ-025 values asynchronously; after release, FIFO empty and no stale output.
